if_id_skid_buf: RTL
===================

IF_ID_SKID_BUF -- requirements
Module: if_id_skid_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of the address and instruction payload fields.
REQ-002 SHALL have parameter NOP_INS, default all-zero DATA_WIDTH value, giving the bubble instruction driven when empty or flushed.
REQ-003 SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have port in_valid_i, input, 1, meaning the upstream fetch payload is valid.
REQ-007 SHALL have port in_ready_o, output, 1, meaning the block accepts a payload this cycle.
REQ-008 SHALL have port addr_plus1_i, input, DATA_WIDTH, the fetched instruction address plus one.
REQ-009 SHALL have port ins_i, input, DATA_WIDTH, the fetched instruction.
REQ-010 SHALL have port keep_i, input, 1, the hazard-unit hold that freezes the output entry.
REQ-011 SHALL have port flush_i, input, 1, the controller flush that discards all entries.
REQ-012 SHALL have port out_valid_o, output, 1, meaning the decode payload is valid.
REQ-013 SHALL have port out_ready_i, input, 1, meaning decode can consume this cycle.
REQ-014 SHALL have port addr_plus1_o, output, DATA_WIDTH, the address-plus-one presented to decode.
REQ-015 SHALL have port ins_o, output, DATA_WIDTH, the instruction presented to decode.
REQ-016 SHALL have port occupancy_o, output, 2, the number of held entries (0, 1 or 2).
REQ-017 SHALL have port stall_cnt_o, output, CNT_W, a saturating count of stalled valid-output cycles.

Function
REQ-018 SHALL hold a two-entry buffer: a main entry driving the outputs and a skid entry; states are EMPTY, ONE and TWO.
REQ-019 SHALL define push = in_valid_i & in_ready_o and pop = out_valid_o & out_ready_i & ~keep_i.
REQ-020 SHALL drive in_ready_o = (state != TWO) and out_valid_o = (state != EMPTY), both purely from registered state, with no combinational path from out_ready_i or keep_i.
REQ-021 SHALL make these transitions: EMPTY with push goes to ONE, main loads the input.
REQ-022 SHALL make these transitions from ONE: push & pop stays ONE, main loads the input; push & ~pop goes to TWO, skid loads the input; pop & ~push goes to EMPTY; otherwise holds.
REQ-023 SHALL make these transitions from TWO: pop goes to ONE, main loads skid; otherwise holds; no push is possible in TWO.
REQ-024 SHALL keep the entry order FIFO, giving zero-bubble throughput of one payload per cycle at steady state.
REQ-025 SHALL give flush_i priority over keep_i, push and pop: next state EMPTY, both entries invalidated, and any same-cycle push discarded.
REQ-026 SHALL drive ins_o = NOP_INS and addr_plus1_o = 0 whenever state is EMPTY, including after a pop-to-empty.
REQ-027 SHALL, while keep_i=1 and flush_i=0, leave the main entry unchanged while the skid entry may still fill.
REQ-028 SHALL increment stall_cnt_o when out_valid_o=1 and pop=0, saturating at all-ones, and SHALL NOT clear it on flush.
REQ-029 SHALL make occupancy_o equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.

Reset
REQ-030 SHALL, when rst_i=1 at a clock edge, set state EMPTY, out_valid_o=0, in_ready_o=1, ins_o=NOP_INS, addr_plus1_o=0, occupancy_o=0, stall_cnt_o=0, and skid contents to 0.
REQ-031 SHALL give reset priority over flush and over all handshake events; reset applied mid-transfer drops all held payloads.

Structure
REQ-032 SHALL take the state encoding (EMPTY/ONE/TWO) and the default NOP_INS value from the shared pipeline package, alongside DATA_WIDTH.
REQ-033 SHALL be a single module with no sub-module; the two entries are plain registers.

Verification
REQ-034 SHALL cover: reset, then in_valid_i=1, ins_i=0x00A0_0013, addr=0x4, out_ready_i=1 -> next cycle out_valid_o=1, ins_o=0x00A0_0013, occupancy_o=1.
REQ-035 SHALL cover: stream 0x11, 0x22, 0x33 with out_ready_i=0 -> occupancy_o reaches 2, in_ready_o=0, 0x33 not accepted; then out_ready_i=1 -> outputs 0x11, then 0x22, then 0x33 in order.
REQ-036 SHALL cover: state TWO with keep_i=1 and out_ready_i=1 for 3 cycles -> ins_o unchanged, stall_cnt_o increases by 3.
REQ-037 SHALL cover: state TWO, then flush_i=1 with in_valid_i=1 and ins_i=0x44 -> next cycle out_valid_o=0, ins_o=NOP_INS, occupancy_o=0, 0x44 never appears.
REQ-038 SHALL cover: flush_i=1 and keep_i=1 together in state ONE -> EMPTY next cycle.
REQ-039 SHALL cover: CNT_W=4 with 20 stalled cycles -> stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/if_id_skid_buf_pkg.sv
// Shared pipeline definitions for the IF/ID skid buffer: default payload
// width, default bubble instruction and the buffer state encoding.
package if_id_skid_buf_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [DATA_WIDTH_DEF-1:0] NOP_INS_DEF = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // Number of held entries for a given buffer state.
  function automatic logic [1:0] occupancy_of(input buf_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/if_id_skid_buf.sv
// IF/ID pipeline register built as a two-entry skid buffer. The main entry
// drives decode directly from flops; the skid entry absorbs one payload when
// decode stalls, so in_ready_o never depends on out_ready_i or keep_i.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | nothing held, outputs show the bubble
// ST_ONE   | main entry valid, skid entry free
// ST_TWO   | main and skid valid, upstream back-pressured
module if_id_skid_buf
  import if_id_skid_buf_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] NOP_INS    = DATA_WIDTH'(NOP_INS_DEF),
  parameter int                    CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] addr_plus1_i,
  input  logic [DATA_WIDTH-1:0] ins_i,
  input  logic                  keep_i,
  input  logic                  flush_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] addr_plus1_o,
  output logic [DATA_WIDTH-1:0] ins_o,
  output logic [1:0]            occupancy_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_addr_q, main_addr_d;
  logic [DATA_WIDTH-1:0] main_ins_q, main_ins_d;
  logic [DATA_WIDTH-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_WIDTH-1:0] skid_ins_q, skid_ins_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic push;
  logic pop;

  assign in_ready_o   = (state_q != ST_TWO);
  assign out_valid_o  = (state_q != ST_EMPTY);
  assign push         = in_valid_i & in_ready_o;
  assign pop          = out_valid_o & out_ready_i & ~keep_i;

  // The main entry is reset to the bubble whenever the buffer empties, so the
  // decode-facing outputs are straight register outputs.
  assign addr_plus1_o = main_addr_q;
  assign ins_o        = main_ins_q;
  assign occupancy_o  = occupancy_of(state_q);
  assign stall_cnt_o  = stall_cnt_q;

  // Next-state and entry movement; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    main_addr_d = main_addr_q;
    main_ins_d  = main_ins_q;
    skid_addr_d = skid_addr_q;
    skid_ins_d  = skid_ins_q;

    if (flush_i) begin
      state_d     = ST_EMPTY;
      main_addr_d = '0;
      main_ins_d  = NOP_INS;
      skid_addr_d = '0;
      skid_ins_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_addr_d = addr_plus1_i;
            main_ins_d  = ins_i;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_addr_d = addr_plus1_i;
            main_ins_d  = ins_i;
          end else if (push) begin
            state_d     = ST_TWO;
            skid_addr_d = addr_plus1_i;
            skid_ins_d  = ins_i;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_addr_d = '0;
            main_ins_d  = NOP_INS;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_addr_d = skid_addr_q;
            main_ins_d  = skid_ins_q;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_addr_d = '0;
          main_ins_d  = NOP_INS;
        end
      endcase
    end
  end

  // Saturating count of cycles where decode holds a valid payload it does not
  // consume; survives flush so stall statistics span pipeline redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !pop && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and entry registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_addr_q <= '0;
      main_ins_q  <= NOP_INS;
      skid_addr_q <= '0;
      skid_ins_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_addr_q <= main_addr_d;
      main_ins_q  <= main_ins_d;
      skid_addr_q <= skid_addr_d;
      skid_ins_q  <= skid_ins_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
